picosoc_mem_fabric: RTL and testbench

Parametrised native-memory-bus interconnect between the picorv32 core and its memory and peripherals, for the LFCPNX-EVN SoC. It replaces fixed single-address peripheral decode with:
- a RAM window of configurable depth;
- `NUM_SLOTS` peripheral windows with per-slot ready handshakes;
- a bus-timeout watchdog;
- error capture (sticky flag, faulting address, interrupt pulse).

It sits directly between the core's `mem_*` / `mem_la_*` ports, a single-port BRAM, and the peripheral blocks (UART, GPIO, timers).

---
 rtl/picosoc_pkg.sv | 24 ++
 rtl/picosoc_mem_fabric_if.sv | 27 ++
 rtl/picosoc_slot_decode.sv | 43 ++++
 rtl/picosoc_mem_fabric.sv | 169 ++++++++++++++++
 tb/tb_picosoc_mem_fabric.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/picosoc_pkg.sv
// Shared definitions for the picorv32 memory fabric: FSM encoding, SoC address map
// constants and the width helper used to size address and index buses.
package picosoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SLOT_WAIT = 2'd1,
        ST_DONE      = 2'd2
    } fabric_state_e;

    localparam logic [31:0] SOC_RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] SOC_SLOT_BASE = 32'h0200_0000;
    localparam logic [31:0] SOC_ERR_RDATA = 32'hDEAD_BEEF;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < value) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/picosoc_mem_fabric_if.sv
// picorv32 native memory bus, including the look-ahead request signals.
interface picosoc_mem_fabric_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_la_read;
    logic        mem_la_write;
    logic [31:0] mem_la_addr;
    logic [31:0] mem_la_wdata;
    logic [3:0]  mem_la_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picosoc_slot_decode.sv
// Combinational address decode: RAM window hit, peripheral slot one-hot and index.
module picosoc_slot_decode
    import picosoc_pkg::*;
#(
    parameter int          MEM_WORDS      = 65536,
    parameter int          NUM_SLOTS      = 4,
    parameter logic [31:0] SLOT_BASE      = SOC_SLOT_BASE,
    parameter int          SLOT_SPAN_BITS = 8,
    parameter int          IDX_W          = 2
) (
    input  logic [31:0]          addr,
    output logic                 ram_hit,
    output logic                 slot_hit,
    output logic [NUM_SLOTS-1:0] slot_onehot,
    output logic [IDX_W-1:0]     slot_idx
);
    localparam logic [32:0] RAM_LIMIT = {1'b0, SOC_RAM_BASE} + (33'(MEM_WORDS) << 2);
    localparam int          TAG_W     = 32 - SLOT_SPAN_BITS;
    localparam logic [31:0] BASE_TAG  = SLOT_BASE >> SLOT_SPAN_BITS;

    logic [NUM_SLOTS-1:0] tag_match;

    assign ram_hit = {1'b0, addr} < RAM_LIMIT;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            localparam logic [31:0] TAG = BASE_TAG + 32'(gi);
            assign tag_match[gi] = (addr[31:SLOT_SPAN_BITS] == TAG[TAG_W-1:0]);
        end
    endgenerate

    // RAM takes priority should a slot window ever overlap it
    assign slot_onehot = ram_hit ? '0 : tag_match;
    assign slot_hit    = |slot_onehot;

    always_comb begin
        slot_idx = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_onehot[k]) slot_idx = slot_idx | IDX_W'(k);
        end
    end
endmodule

// File: rtl/picosoc_mem_fabric.sv
// picorv32 memory interconnect: look-ahead BRAM path, slot FSM with bus-timeout
// watchdog, and sticky error capture with a one-cycle interrupt pulse.
module picosoc_mem_fabric
    import picosoc_pkg::*;
#(
    parameter int          MEM_WORDS      = 65536,
    parameter int          NUM_SLOTS      = 4,
    parameter logic [31:0] SLOT_BASE      = SOC_SLOT_BASE,
    parameter int          SLOT_SPAN_BITS = 8,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = SOC_ERR_RDATA,
    localparam int         AW             = clog2(MEM_WORDS)
) (
    input  logic                      clk,
    input  logic                      reset,
    picosoc_mem_fabric_if.slave       bus,
    output logic [AW-1:0]             ram_addr,
    output logic [31:0]               ram_din,
    output logic [3:0]                ram_we,
    input  logic [31:0]               ram_dout,
    output logic [NUM_SLOTS-1:0]      slot_sel,
    output logic [SLOT_SPAN_BITS-1:0] slot_addr,
    output logic [31:0]               slot_wdata,
    output logic [3:0]                slot_wstrb,
    input  logic [32*NUM_SLOTS-1:0]   slot_rdata,
    input  logic [NUM_SLOTS-1:0]      slot_ready,
    input  logic                      err_clr,
    output logic                      bus_err,
    output logic                      err_irq,
    output logic [31:0]               err_addr
);
    localparam int          IDX_W        = (NUM_SLOTS > 1) ? clog2(NUM_SLOTS) : 1;
    localparam logic [32:0] RAM_LIMIT    = {1'b0, SOC_RAM_BASE} + (33'(MEM_WORDS) << 2);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0]  IDLE         = ST_IDLE;
    localparam logic [1:0]  SLOT_WAIT    = ST_SLOT_WAIT;
    localparam logic [1:0]  DONE         = ST_DONE;

    logic [1:0]           state_reg, state_next;
    logic [15:0]          cnt_reg, cnt_next;
    logic [NUM_SLOTS-1:0] sel_reg, sel_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [31:0]          rdata_reg, rdata_next;
    logic                 err_cur_reg, err_cur_next;
    logic                 ram_ready_reg, ram_ready_next;
    logic                 bus_err_reg, bus_err_next;
    logic [31:0]          err_addr_reg, err_addr_next;

    logic                 ram_hit, slot_hit, la_in_ram, sel_ready, err_event;
    logic [NUM_SLOTS-1:0] slot_onehot;
    logic [IDX_W-1:0]     slot_idx;
    logic                 unused_instr;

    picosoc_slot_decode #(
        .MEM_WORDS      (MEM_WORDS),
        .NUM_SLOTS      (NUM_SLOTS),
        .SLOT_BASE      (SLOT_BASE),
        .SLOT_SPAN_BITS (SLOT_SPAN_BITS),
        .IDX_W          (IDX_W)
    ) u_decode (
        .addr        (bus.mem_addr),
        .ram_hit     (ram_hit),
        .slot_hit    (slot_hit),
        .slot_onehot (slot_onehot),
        .slot_idx    (slot_idx)
    );

    assign unused_instr = bus.mem_instr;

    // BRAM is driven from the look-ahead bus so its registered read lines up with mem_valid
    assign la_in_ram      = {1'b0, bus.mem_la_addr} < RAM_LIMIT;
    assign ram_addr       = bus.mem_la_addr[AW+1:2];
    assign ram_din        = bus.mem_la_wdata;
    assign ram_we         = (bus.mem_la_write && la_in_ram) ? bus.mem_la_wstrb : 4'b0000;
    assign ram_ready_next = (bus.mem_la_read || bus.mem_la_write) && !bus.mem_ready && la_in_ram;

    assign sel_ready  = slot_ready[idx_reg];
    assign slot_sel   = (state_reg == SLOT_WAIT) ? sel_reg : '0;
    assign slot_addr  = bus.mem_addr[SLOT_SPAN_BITS-1:0];
    assign slot_wdata = bus.mem_wdata;
    assign slot_wstrb = bus.mem_wstrb;

    assign bus.mem_ready = ram_ready_reg || (state_reg == DONE);
    assign bus.mem_rdata = ram_ready_reg ? ram_dout : ((state_reg == DONE) ? rdata_reg : 32'h0);
    assign err_irq       = (state_reg == DONE) && err_cur_reg;
    assign bus_err       = bus_err_reg;
    assign err_addr      = err_addr_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        sel_next     = sel_reg;
        idx_next     = idx_reg;
        rdata_next   = rdata_reg;
        err_cur_next = err_cur_reg;
        err_event    = 1'b0;
        case (state_reg)
            IDLE: begin
                err_cur_next = 1'b0;
                if (bus.mem_valid && !bus.mem_ready) begin
                    if (slot_hit) begin
                        state_next = SLOT_WAIT;
                        cnt_next   = '0;
                        sel_next   = slot_onehot;
                        idx_next   = slot_idx;
                    end else if (!ram_hit) begin
                        state_next   = DONE;
                        rdata_next   = ERR_RDATA;
                        err_cur_next = 1'b1;
                        err_event    = 1'b1;
                    end
                end
            end
            SLOT_WAIT: begin
                cnt_next = cnt_reg + 16'd1;
                if (sel_ready) begin
                    state_next = DONE;
                    rdata_next = slot_rdata[32*idx_reg +: 32];
                // ready is sampled in wait cycles 0..TIMEOUT_CYCLES before giving up
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next   = DONE;
                    rdata_next   = ERR_RDATA;
                    err_cur_next = 1'b1;
                    err_event    = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new error outranks a simultaneous clear and then owns err_addr
    always_comb begin
        bus_err_next  = bus_err_reg;
        err_addr_next = err_addr_reg;
        if (err_clr) begin
            bus_err_next  = 1'b0;
            err_addr_next = 32'h0;
        end
        if (err_event) begin
            bus_err_next = 1'b1;
            if (!bus_err_reg || err_clr) err_addr_next = bus.mem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sel_reg       <= '0;
            idx_reg       <= '0;
            rdata_reg     <= '0;
            err_cur_reg   <= 1'b0;
            ram_ready_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
            err_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sel_reg       <= sel_next;
            idx_reg       <= idx_next;
            rdata_reg     <= rdata_next;
            err_cur_reg   <= err_cur_next;
            ram_ready_reg <= ram_ready_next;
            bus_err_reg   <= bus_err_next;
            err_addr_reg  <= err_addr_next;
        end
    end
endmodule

// File: tb/tb_picosoc_mem_fabric.sv
// Directed bench for picosoc_mem_fabric: RAM look-ahead path, slot handshake,
// timeout, unmapped errors, error clear and reset during a slot wait.
module tb_picosoc_mem_fabric;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [9:0]   ram_addr;
    logic [31:0]  ram_din, ram_dout;
    logic [3:0]   ram_we;
    logic [3:0]   slot_sel;
    logic [7:0]   slot_addr;
    logic [31:0]  slot_wdata;
    logic [3:0]   slot_wstrb;
    logic [127:0] slot_rdata;
    logic [3:0]   slot_ready;
    logic         err_clr, bus_err, err_irq;
    logic [31:0]  err_addr;

    int total = 0;
    int bad   = 0;

    picosoc_mem_fabric_if bus();

    picosoc_mem_fabric #(
        .MEM_WORDS      (1024),
        .NUM_SLOTS      (4),
        .SLOT_BASE      (32'h0200_0000),
        .SLOT_SPAN_BITS (8),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .slot_sel   (slot_sel),
        .slot_addr  (slot_addr),
        .slot_wdata (slot_wdata),
        .slot_wstrb (slot_wstrb),
        .slot_rdata (slot_rdata),
        .slot_ready (slot_ready),
        .err_clr    (err_clr),
        .bus_err    (bus_err),
        .err_irq    (err_irq),
        .err_addr   (err_addr)
    );

    // single-port BRAM with registered read, read-before-write
    logic [31:0] ram_mem [0:1023];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.mem_valid    = 1'b0;
        bus.mem_instr    = 1'b0;
        bus.mem_addr     = 32'h0;
        bus.mem_wdata    = 32'h0;
        bus.mem_wstrb    = 4'h0;
        bus.mem_la_read  = 1'b0;
        bus.mem_la_write = 1'b0;
        bus.mem_la_addr  = 32'h0;
        bus.mem_la_wdata = 32'h0;
        bus.mem_la_wstrb = 4'h0;
    endtask

    task automatic ram_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input bit wr, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        bus.mem_la_read  = !wr;
        bus.mem_la_write = wr;
        bus.mem_la_addr  = addr;
        bus.mem_la_wdata = wdata;
        bus.mem_la_wstrb = wr ? wstrb : 4'h0;
        bus.mem_valid    = 1'b1;
        bus.mem_addr     = addr;
        bus.mem_wdata    = wdata;
        bus.mem_wstrb    = wr ? wstrb : 4'h0;
        #1;
        check_val({tag, ".we"}, 32'(ram_we), wr ? 32'(wstrb) : 32'h0);
        @(posedge clk); #1;
        check_val({tag, ".ready"}, 32'(bus.mem_ready), 32'h1);
        if (!wr) check_val({tag, ".rdata"}, bus.mem_rdata, exp_rd);
        idle_bus();
        @(posedge clk); #1;
        check_val({tag, ".ready_low"}, 32'(bus.mem_ready), 32'h0);
        $display("txn %s addr=%h wr=%0d data=%h", tag, addr, wr, wr ? wdata : exp_rd);
    endtask

    task automatic slot_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int ready_at, input logic [3:0] noise,
                            input logic [3:0] exp_sel, input logic [31:0] exp_rdata,
                            input int exp_lat, input int exp_irqs);
        int  c;
        int  irqs;
        bit  seen;
        logic [31:0] rd;
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        @(posedge clk); #1;
        check_val({tag, ".sel"}, 32'(slot_sel), 32'(exp_sel));
        check_val({tag, ".addr"}, 32'(slot_addr), 32'(addr[7:0]));
        check_val({tag, ".wstrb"}, 32'(slot_wstrb), 32'(wstrb));
        check_val({tag, ".wdata"}, slot_wdata, wdata);
        c = 0; irqs = 0; seen = 1'b0; rd = 32'h0;
        while (c < 40 && !seen) begin
            slot_ready = (c == ready_at) ? exp_sel : noise;
            @(posedge clk); #1;
            c++;
            if (err_irq) irqs++;
            if (bus.mem_ready) begin
                seen = 1'b1;
                rd   = bus.mem_rdata;
                check_val({tag, ".sel_done"}, 32'(slot_sel), 32'h0);
            end
        end
        check_val({tag, ".latency"}, 32'(c), 32'(exp_lat));
        check_val({tag, ".rdata"}, rd, exp_rdata);
        idle_bus();
        slot_ready = 4'h0;
        @(posedge clk); #1;
        if (err_irq) irqs++;
        check_val({tag, ".ready_low"}, 32'(bus.mem_ready), 32'h0);
        check_val({tag, ".irqs"}, 32'(irqs), 32'(exp_irqs));
        $display("txn %s addr=%h lat=%0d rdata=%h", tag, addr, c, rd);
    endtask

    task automatic unmapped_txn(input string tag, input logic [31:0] addr, input bit clr);
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = 32'h5555_AAAA;
        bus.mem_wstrb = 4'hF;
        err_clr       = clr;
        @(posedge clk); #1;
        check_val({tag, ".ready"}, 32'(bus.mem_ready), 32'h1);
        check_val({tag, ".rdata"}, bus.mem_rdata, 32'hDEAD_BEEF);
        check_val({tag, ".irq"}, 32'(err_irq), 32'h1);
        check_val({tag, ".bus_err"}, 32'(bus_err), 32'h1);
        idle_bus();
        err_clr = 1'b0;
        @(posedge clk); #1;
        check_val({tag, ".ready_low"}, 32'(bus.mem_ready), 32'h0);
        check_val({tag, ".irq_low"}, 32'(err_irq), 32'h0);
        $display("txn %s addr=%h clr=%0d err_addr=%h", tag, addr, clr, err_addr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        err_clr    = 1'b0;
        slot_ready = 4'h0;
        slot_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.mem_ready", 32'(bus.mem_ready), 32'h0);
        check_val("rst.mem_rdata", bus.mem_rdata, 32'h0);
        check_val("rst.slot_sel", 32'(slot_sel), 32'h0);
        check_val("rst.ram_we", 32'(ram_we), 32'h0);
        check_val("rst.bus_err", 32'(bus_err), 32'h0);
        check_val("rst.err_irq", 32'(err_irq), 32'h0);
        check_val("rst.err_addr", err_addr, 32'h0);
        reset = 1'b0;

        ram_txn("ram_wr_full", 32'h0000_0100, 32'hAABB_CCDD, 4'b1111, 1'b1, 32'h0);
        ram_txn("ram_wr_half", 32'h0000_0100, 32'h1234_5678, 4'b0011, 1'b1, 32'h0);
        ram_txn("ram_rd", 32'h0000_0100, 32'h0, 4'b0000, 1'b0, 32'hAABB_5678);

        slot_txn("slot1_rd", 32'h0200_0104, 32'h0, 4'h0, 3, 4'b1101, 4'b0010, 32'h2222_2222, 4, 0);
        check_val("slot1_rd.bus_err", 32'(bus_err), 32'h0);
        slot_txn("slot0_wr", 32'h0200_0010, 32'hCAFE_F00D, 4'hF, 0, 4'b0000, 4'b0001, 32'h1111_1111, 1, 0);

        slot_txn("slot2_timeout", 32'h0200_0200, 32'h0, 4'h0, -1, 4'b1011, 4'b0100, 32'hDEAD_BEEF, 9, 1);
        check_val("timeout.bus_err", 32'(bus_err), 32'h1);
        check_val("timeout.err_addr", err_addr, 32'h0200_0200);

        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_val("clr.bus_err", 32'(bus_err), 32'h0);

        unmapped_txn("unmap0", 32'h3000_0000, 1'b0);
        check_val("unmap0.err_addr", err_addr, 32'h3000_0000);
        unmapped_txn("unmap1", 32'h3000_0004, 1'b0);
        check_val("unmap1.err_addr", err_addr, 32'h3000_0000);
        unmapped_txn("unmap_clr", 32'h3000_0008, 1'b1);
        check_val("unmap_clr.err_addr", err_addr, 32'h3000_0008);

        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0200_0300;
        @(posedge clk); #1;
        check_val("rst_mid.sel_before", 32'(slot_sel), 32'h8);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_bus();
        @(posedge clk); #1;
        reset = 1'b0;
        check_val("rst_mid.slot_sel", 32'(slot_sel), 32'h0);
        check_val("rst_mid.mem_ready", 32'(bus.mem_ready), 32'h0);
        check_val("rst_mid.bus_err", 32'(bus_err), 32'h0);
        check_val("rst_mid.err_addr", err_addr, 32'h0);
        $display("txn rst_mid addr=02000300 reset during slot wait");

        slot_txn("slot3_after_rst", 32'h0200_0300, 32'h0, 4'h0, 1, 4'b0000, 4'b1000, 32'h4444_4444, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
